led_fader_multi: RTL and testbench
==================================

LED_FADER_MULTI -- requirements
Module: led_fader_multi

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter TICK_HZ, default 100, level-update rate in Hz; TICK_PERIOD = CLK_FREQ/TICK_HZ cycles, which SHALL be at least 2.
REQ-003 SHALL provide parameter CH, default 3, channel count, range 1..16.
REQ-004 SHALL provide parameter PWM_W, default 8, level and PWM counter width, range 2..16.
REQ-005 CLK  in  1  clock; all state updates on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 MODE  in  2  00 sweep (wrap), 01 triangle (bounce), 10 hold, 11 off.
REQ-008 CFG_VALID  in  1  config write request.
REQ-009 CFG_READY  out  1  config write accepted when CFG_VALID and CFG_READY are both high.
REQ-010 CFG_CH  in  max(1,clog2(CH))  target channel.
REQ-011 CFG_LEVEL  in  PWM_W  new level.
REQ-012 CFG_STEP  in  PWM_W  new per-tick step.
REQ-013 TICK  out  1  one-cycle pulse per update period.
REQ-014 LEDS  out  CH  PWM output, one bit per channel; bit i drives channel i.

Function
REQ-015 Tick counter SHALL count 0..TICK_PERIOD-1 and wrap to 0; TICK SHALL be high exactly when the counter equals TICK_PERIOD-1.
REQ-016 PWM counter SHALL be free-running, PWM_W wide, wrapping from 2^PWM_W-1 to 0.
REQ-017 LEDS[i] SHALL be registered as (level[i] > pwm_cnt), so LEDS lags the compare inputs by 1 cycle; level 0 gives constant 0; level 2^PWM_W-1 gives high for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-018 Each channel SHALL hold level[i] (PWM_W bits), step[i] (PWM_W bits) and dir[i] (1 = up).
REQ-019 Levels SHALL update only on the clock edge where TICK is high, according to the MODE sampled on that edge.
REQ-020 Sweep: level = (level + step) mod 2^PWM_W; dir is unchanged.
REQ-021 Triangle, dir up: if level + step >= 2^PWM_W-1, level becomes 2^PWM_W-1 and dir becomes down; otherwise level = level + step.
REQ-022 Triangle, dir down: if level <= step, level becomes 0 and dir becomes up; otherwise level = level - step.
REQ-023 Hold: level and dir are unchanged.
REQ-024 Off: level and dir are unchanged, and LEDS SHALL be forced to 0 on the next edge.
REQ-025 A step of 0 SHALL leave the level unchanged in every mode; in triangle mode, dir changes only under the boundary conditions of REQ-021/REQ-022.
REQ-026 CFG_READY SHALL be low when RST is high or TICK is high, and high otherwise (combinational).
REQ-027 On an accepted write with CFG_CH < CH: level[CFG_CH] = CFG_LEVEL, step[CFG_CH] = CFG_STEP, dir[CFG_CH] = up, all on that edge.
REQ-028 An accepted write with CFG_CH >= CH SHALL be consumed with no state change.
REQ-029 A MODE change SHALL not reset levels, dirs or counters; sweep-to-triangle keeps the existing dir.

Reset
REQ-030 When RST is high at an edge: tick counter = 0, pwm_cnt = 0, LEDS = 0, TICK = 0, CFG_READY = 0.
REQ-031 Reset values per channel: level[i] = floor(i*2^PWM_W/CH); step[i] = 2^(i mod PWM_W); dir[i] = up. Defaults give levels 0/85/170 and steps 1/2/4.
REQ-032 Reset asserted mid-period or during a CFG handshake SHALL abort it; no partial write is retained.

Verification
REQ-033 CLK_FREQ=1000, TICK_HZ=100; release reset -> TICK high on cycles 9, 19, 29 after release; CFG_READY low on exactly those cycles.
REQ-034 Defaults, MODE=00; after 1 tick, levels = 1/87/174; after 256 ticks, levels = 0/85/170 (wrap).
REQ-035 MODE=01; write ch0 level 250, step 10 -> next tick level 255 with dir down; next tick 245; write level 5, step 10 with dir forced to down by prior ticks -> descending reaches 0, then dir up.
REQ-036 Set level 0 and level 255 on two channels -> over 256 cycles, LEDS bit high 0 times and 255 times respectively; MODE=11 -> LEDS = 0 within 1 cycle; MODE=10 after that -> levels match their pre-off values.
REQ-037 Write with CFG_CH=3 (CH=3) -> CFG_READY handshake completes and no level changes; assert RST mid-period with CFG_VALID high -> all state returns to the REQ-030/REQ-031 values.

Source files
------------

// File: rtl/led_fader_multi.sv
// Multi-channel LED fader: per-channel level/step/direction, updated once per tick,
// with a free-running PWM comparator driving one LED bit per channel.
module led_fader_multi #(
    parameter int CLK_FREQ = 100000000,
    parameter int TICK_HZ  = 100,
    parameter int CH       = 3,
    parameter int PWM_W    = 8,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [CH_W-1:0]  CFG_CH,
    input  logic [PWM_W-1:0] CFG_LEVEL,
    input  logic [PWM_W-1:0] CFG_STEP,
    output logic             TICK,
    output logic [CH-1:0]    LEDS
);

    localparam int TICK_PERIOD = CLK_FREQ / TICK_HZ;
    localparam int TCNT_W      = $clog2(TICK_PERIOD);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_PERIOD - 1);
    localparam logic [PWM_W-1:0]  LVL_MAX   = {PWM_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_SWEEP = 2'b00,
        MODE_TRI   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    // Channels start evenly spread across the level range.
    function automatic logic [PWM_W-1:0] reset_level(input int idx);
        int scaled;
        scaled = (idx * (32'sd1 <<< PWM_W)) / CH;
        return PWM_W'(scaled);
    endfunction

    function automatic logic [PWM_W-1:0] reset_step(input int idx);
        return PWM_W'(32'd1 << (idx % PWM_W));
    endfunction

    logic [TCNT_W-1:0] tick_cnt_r;
    logic [TCNT_W-1:0] tick_cnt_nxt_s;
    logic              tick_r;
    logic [PWM_W-1:0]  pwm_cnt_r;
    logic [CH-1:0]     leds_r;
    logic [CH-1:0]     leds_nxt_s;
    logic [PWM_W-1:0]  level_r     [CH];
    logic [PWM_W-1:0]  step_r      [CH];
    logic [CH-1:0]     dir_r;
    logic [PWM_W-1:0]  level_nxt_s [CH];
    logic [CH-1:0]     dir_nxt_s;
    logic [PWM_W:0]    sum_s       [CH];
    logic              cfg_accept_s;

    assign CFG_READY    = !RST && !tick_r;
    assign cfg_accept_s = CFG_VALID && CFG_READY;
    assign TICK         = tick_r;
    assign LEDS         = leds_r;

    // Tick counter next value; TICK is registered so it lines up with the counter's last value.
    always_comb begin
        tick_cnt_nxt_s = tick_cnt_r + TCNT_W'(1);
        if (tick_cnt_r == TCNT_LAST) begin
            tick_cnt_nxt_s = '0;
        end else begin
            tick_cnt_nxt_s = tick_cnt_r + TCNT_W'(1);
        end
    end

    // Per-channel level/direction update for the current mode, plus PWM compare.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            level_nxt_s[i] = level_r[i];
            dir_nxt_s[i]   = dir_r[i];
            sum_s[i]       = {1'b0, level_r[i]} + {1'b0, step_r[i]};
            leds_nxt_s[i]  = 1'b0;

            case (mode_e'(MODE))
                MODE_SWEEP: begin
                    level_nxt_s[i] = sum_s[i][PWM_W-1:0];
                end
                MODE_TRI: begin
                    if (dir_r[i]) begin
                        if (sum_s[i] >= {1'b0, LVL_MAX}) begin
                            level_nxt_s[i] = LVL_MAX;
                            dir_nxt_s[i]   = 1'b0;
                        end else begin
                            level_nxt_s[i] = sum_s[i][PWM_W-1:0];
                        end
                    end else begin
                        if (level_r[i] <= step_r[i]) begin
                            level_nxt_s[i] = '0;
                            dir_nxt_s[i]   = 1'b1;
                        end else begin
                            level_nxt_s[i] = level_r[i] - step_r[i];
                        end
                    end
                end
                default: begin
                    level_nxt_s[i] = level_r[i];
                    dir_nxt_s[i]   = dir_r[i];
                end
            endcase

            if (mode_e'(MODE) == MODE_OFF) begin
                leds_nxt_s[i] = 1'b0;
            end else begin
                leds_nxt_s[i] = (level_r[i] > pwm_cnt_r);
            end
        end
    end

    // Counters, outputs and channel state; config writes cannot collide with a tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
            pwm_cnt_r  <= '0;
            leds_r     <= '0;
            dir_r      <= '1;
            for (int i = 0; i < CH; i++) begin
                level_r[i] <= reset_level(i);
                step_r[i]  <= reset_step(i);
            end
        end else begin
            tick_cnt_r <= tick_cnt_nxt_s;
            tick_r     <= (tick_cnt_nxt_s == TCNT_LAST);
            pwm_cnt_r  <= pwm_cnt_r + PWM_W'(1);
            leds_r     <= leds_nxt_s;
            for (int i = 0; i < CH; i++) begin
                if (tick_r) begin
                    level_r[i] <= level_nxt_s[i];
                    dir_r[i]   <= dir_nxt_s[i];
                end else if (cfg_accept_s && (32'(CFG_CH) == i)) begin
                    level_r[i] <= CFG_LEVEL;
                    step_r[i]  <= CFG_STEP;
                    dir_r[i]   <= 1'b1;
                end else begin
                    level_r[i] <= level_r[i];
                    dir_r[i]   <= dir_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_fader_multi.sv
// Directed bench for led_fader_multi: levels are observed by counting LED duty over 256 cycles in hold mode.
module tb_led_fader_multi;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_level;
    logic [7:0] cfg_step;
    logic       tick;
    logic [2:0] leds;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] M_SWEEP = 2'b00;
    localparam logic [1:0] M_TRI   = 2'b01;
    localparam logic [1:0] M_HOLD  = 2'b10;
    localparam logic [1:0] M_OFF   = 2'b11;

    led_fader_multi #(
        .CLK_FREQ(1000),
        .TICK_HZ (100),
        .CH      (3),
        .PWM_W   (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .MODE     (mode),
        .CFG_VALID(cfg_valid),
        .CFG_READY(cfg_ready),
        .CFG_CH   (cfg_ch),
        .CFG_LEVEL(cfg_level),
        .CFG_STEP (cfg_step),
        .TICK     (tick),
        .LEDS     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Duty count per channel over 256 consecutive cycles equals the level.
    task automatic measure(output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            c0 += int'(leds[0]);
            c1 += int'(leds[1]);
            c2 += int'(leds[2]);
        end
    endtask

    // Apply mode m on exactly n tick edges, holding otherwise.
    task automatic do_ticks(input logic [1:0] m, input int n);
        int w;
        for (int j = 0; j < n; j++) begin
            w = 0;
            @(negedge clk);
            while (!tick && w < 30) begin
                @(negedge clk);
                w++;
            end
            if (!tick) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: tick never rose, required within 30 cycles");
            end
            mode = m;
            @(posedge clk);
            #1 mode = M_HOLD;
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] lvl, input logic [7:0] stp,
                             output bit ok);
        int w;
        cfg_ch = ch; cfg_level = lvl; cfg_step = stp; cfg_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!cfg_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        ok = cfg_ready;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        int c0, c1, c2;
        logic exp_tick;
        rst = 1'b1; mode = M_HOLD; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_level = 8'd0; cfg_step = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({leds, tick, cfg_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: leds=%b tick=%b ready=%b required 000 0 0", leds, tick, cfg_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_tick = ((k % 10) == 9) ? 1'b1 : 1'b0;
            checks++;
            if (tick !== exp_tick || cfg_ready !== !exp_tick) begin
                errors++;
                $display("FAIL tick_cycle_%0d: tick=%b ready=%b required tick=%b ready=%b",
                         k, tick, cfg_ready, exp_tick, !exp_tick);
            end
        end
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 0 || c1 !== 85 || c2 !== 170) begin
            errors++;
            $display("FAIL reset_levels: got %0d/%0d/%0d required 0/85/170", c0, c1, c2);
        end
    endtask

    task automatic test_sweep;
        int c0, c1, c2;
        do_ticks(M_SWEEP, 1);
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 1 || c1 !== 87 || c2 !== 174) begin
            errors++;
            $display("FAIL sweep_1tick: got %0d/%0d/%0d required 1/87/174", c0, c1, c2);
        end
        do_ticks(M_SWEEP, 255);
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 0 || c1 !== 85 || c2 !== 170) begin
            errors++;
            $display("FAIL sweep_wrap: got %0d/%0d/%0d required 0/85/170", c0, c1, c2);
        end
    endtask

    task automatic test_triangle;
        int c0, c1, c2;
        bit ok;
        int exp_lvl [5] = '{255, 245, 5, 0, 10};
        int n_ticks [5] = '{1, 1, 24, 1, 1};
        cfg_write(2'd0, 8'd250, 8'd10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tri_cfg_handshake: ready=%b required 1", ok);
        end
        for (int s = 0; s < 5; s++) begin
            do_ticks(M_TRI, n_ticks[s]);
            measure(c0, c1, c2);
            checks++;
            if (c0 !== exp_lvl[s]) begin
                errors++;
                $display("FAIL tri_step_%0d: ch0 level=%0d required %0d", s, c0, exp_lvl[s]);
            end
        end
    endtask

    task automatic test_pwm_off;
        int c0, c1, c2;
        int nonzero;
        bit ok1, ok2;
        cfg_write(2'd1, 8'd0, 8'd0, ok1);
        cfg_write(2'd2, 8'd255, 8'd0, ok2);
        measure(c0, c1, c2);
        checks++;
        if (!ok1 || !ok2 || c0 !== 10 || c1 !== 0 || c2 !== 255) begin
            errors++;
            $display("FAIL pwm_extremes: ok=%b%b duty %0d/%0d/%0d required 11 10/0/255", ok1, ok2, c0, c1, c2);
        end
        do_ticks(M_SWEEP, 1);
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 20 || c1 !== 0 || c2 !== 255) begin
            errors++;
            $display("FAIL step_zero_sweep: got %0d/%0d/%0d required 20/0/255", c0, c1, c2);
        end
        mode = M_OFF;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (leds !== 3'b000) begin
            errors++;
            $display("FAIL off_first_cycle: leds=%b required 000", leds);
        end
        nonzero = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (leds !== 3'b000) nonzero++;
        end
        checks++;
        if (nonzero !== 0) begin
            errors++;
            $display("FAIL off_sustained: %0d cycles with leds lit, required 0", nonzero);
        end
        @(posedge clk);
        #1 mode = M_HOLD;
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 20 || c1 !== 0 || c2 !== 255) begin
            errors++;
            $display("FAIL hold_after_off: got %0d/%0d/%0d required 20/0/255", c0, c1, c2);
        end
    endtask

    task automatic test_bad_channel;
        int c0, c1, c2;
        bit ok;
        cfg_write(2'd3, 8'd7, 8'd7, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL badch_handshake: ready=%b required 1", ok);
        end
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 20 || c1 !== 0 || c2 !== 255) begin
            errors++;
            $display("FAIL badch_levels: got %0d/%0d/%0d required 20/0/255", c0, c1, c2);
        end
    endtask

    task automatic test_reset_mid;
        int c0, c1, c2;
        logic exp_tick;
        repeat (4) @(posedge clk);
        #1;
        cfg_ch = 2'd0; cfg_level = 8'd100; cfg_step = 8'd3; cfg_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_comb: ready=%b required 0", cfg_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({leds, tick, cfg_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_outputs: leds=%b tick=%b ready=%b required 000 0 0", leds, tick, cfg_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0; cfg_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_tick = (k == 9) ? 1'b1 : 1'b0;
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL rst_mid_tick_%0d: tick=%b required %b", k, tick, exp_tick);
            end
        end
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 0 || c1 !== 85 || c2 !== 170) begin
            errors++;
            $display("FAIL rst_mid_levels: got %0d/%0d/%0d required 0/85/170", c0, c1, c2);
        end
        do_ticks(M_SWEEP, 1);
        measure(c0, c1, c2);
        checks++;
        if (c0 !== 1 || c1 !== 87 || c2 !== 174) begin
            errors++;
            $display("FAIL rst_mid_steps: got %0d/%0d/%0d required 1/87/174", c0, c1, c2);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_triangle();
        test_pwm_off();
        test_bad_channel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
